// File: rtl/sand_pkg.sv
// Shared constants and types for the sand cell-RAM datapath.
// Used by the scheduler, its FIFO and the bus interface.
package sand_pkg;
    localparam int ACTIVE_COLUMNS = 640;
    localparam int ACTIVE_ROWS    = 480;
    localparam int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS);
    localparam int DATA_WIDTH     = 1;

    typedef logic [DATA_WIDTH-1:0] cell_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        STEP
    } sched_state_t;
endpackage

// File: rtl/cell_mem_scheduler_if.sv
// Engine, spawn and RAM-port signals of the cell RAM scheduler.
// Signal suffixes are from the scheduler's point of view.
interface cell_mem_scheduler_if
    import sand_pkg::*;
#(
    parameter int AW = ADDR_WIDTH,
    parameter int DW = DATA_WIDTH
);
    logic          frame_tick_i;
    logic          eng_ready_o;
    logic          eng_done_i;
    logic [AW-1:0] eng_read_address_i;
    logic [AW-1:0] eng_write_address_i;
    logic [DW-1:0] eng_write_data_i;
    logic          eng_wr_ena_i;
    logic          spawn_valid_i;
    logic [AW-1:0] spawn_address_i;
    logic [DW-1:0] spawn_data_i;
    logic          spawn_ready_o;
    logic [AW-1:0] mem_read_address_o;
    logic [AW-1:0] mem_write_address_o;
    logic [DW-1:0] mem_write_data_o;
    logic          mem_wr_ena_o;
    logic          busy_o;
    logic          overrun_o;
    logic          timeout_o;

    modport slave (
        input  frame_tick_i, eng_done_i,
        input  eng_read_address_i, eng_write_address_i,
        input  eng_write_data_i, eng_wr_ena_i,
        input  spawn_valid_i, spawn_address_i, spawn_data_i,
        output eng_ready_o, spawn_ready_o,
        output mem_read_address_o, mem_write_address_o,
        output mem_write_data_o, mem_wr_ena_o,
        output busy_o, overrun_o, timeout_o
    );

    modport master (
        output frame_tick_i, eng_done_i,
        output eng_read_address_i, eng_write_address_i,
        output eng_write_data_i, eng_wr_ena_i,
        output spawn_valid_i, spawn_address_i, spawn_data_i,
        input  eng_ready_o, spawn_ready_o,
        input  mem_read_address_o, mem_write_address_o,
        input  mem_write_data_o, mem_wr_ena_o,
        input  busy_o, overrun_o, timeout_o
    );
endinterface

// File: rtl/cell_mem_scheduler_spawn_fifo.sv
// Small synchronous FIFO holding pending brush/spawn writes.
// DEPTH must be a power of two, at least 2.
module spawn_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wr;
    logic [PW:0]      r_rd;
    logic             w_push;
    logic             w_pop;

    // Extra pointer bit separates full from empty.
    assign empty_o = (r_wr == r_rd);
    assign full_o  = (r_wr[PW] != r_rd[PW]) &&
                     (r_wr[PW-1:0] == r_rd[PW-1:0]);
    assign head_o  = r_mem[r_rd[PW-1:0]];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr[PW-1:0]] <= push_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end
endmodule

// File: rtl/cell_mem_scheduler.sv
// Step sequencer and cell-RAM port arbiter (engine vs. spawn FIFO).
// Define CELL_SCHED_WATCHDOG_EN to build the STEP watchdog.
module cell_mem_scheduler
    import sand_pkg::*;
#(
    parameter int ACTIVE_COLUMNS = sand_pkg::ACTIVE_COLUMNS,
    parameter int ACTIVE_ROWS    = sand_pkg::ACTIVE_ROWS,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = sand_pkg::DATA_WIDTH,
    parameter int STEP_DIVIDE    = 1,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1228800
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    cell_mem_scheduler_if.slave  bus
);
    localparam int DIVW = (STEP_DIVIDE > 1) ? $clog2(STEP_DIVIDE) : 1;
    localparam int FW   = ADDR_WIDTH + DATA_WIDTH;

    sched_state_t    r_state;
    logic [DIVW-1:0] r_div;
    logic            r_pending;
    logic            r_overrun;
    logic            r_timeout;
    logic            w_trig;
    logic            w_eng;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [FW-1:0]   w_head;

    assign w_trig = bus.frame_tick_i &&
                    (r_div == DIVW'(STEP_DIVIDE - 1));
    assign w_eng  = (r_state != IDLE) && !reset_i;
    assign w_pop  = (r_state == IDLE) && !w_trig && !r_pending &&
                    !w_empty && !reset_i;

    spawn_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (bus.spawn_valid_i),
        .push_data_i ({bus.spawn_address_i, bus.spawn_data_i}),
        .pop_i       (w_pop),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .head_o      (w_head)
    );

`ifdef CELL_SCHED_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wdog;
    logic          w_wd_hit;
    // Fires on the STEP cycle that brings the count to TIMEOUT_CYCLES.
    assign w_wd_hit = (r_wdog == TW'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= IDLE;
            r_div     <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
`ifdef CELL_SCHED_WATCHDOG_EN
            r_wdog    <= '0;
`endif
        end else begin
            if (bus.frame_tick_i)
                r_div <= w_trig ? '0 : r_div + 1'b1;
            unique case (r_state)
                IDLE: begin
                    if (w_trig || r_pending) begin
                        r_state   <= START;
                        r_pending <= 1'b0;
`ifdef CELL_SCHED_WATCHDOG_EN
                        r_wdog    <= '0;
`endif
                    end
                end
                START: r_state <= STEP;
                STEP: begin
                    if (bus.eng_done_i) begin
                        r_state <= IDLE;
`ifdef CELL_SCHED_WATCHDOG_EN
                    end else if (w_wd_hit) begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
            // Only one step is ever owed, however many triggers land.
            if (w_trig && (r_state != IDLE)) begin
                r_pending <= 1'b1;
                r_overrun <= 1'b1;
            end
`ifdef CELL_SCHED_WATCHDOG_EN
            if (r_state == STEP) r_wdog <= r_wdog + 1'b1;
`endif
        end
    end

    assign bus.eng_ready_o   = (r_state == START) && !reset_i;
    assign bus.busy_o        = w_eng;
    assign bus.overrun_o     = r_overrun && !reset_i;
    assign bus.timeout_o     = r_timeout && !reset_i;
    assign bus.spawn_ready_o = !w_full || reset_i;

    always_comb begin
        bus.mem_read_address_o  = '0;
        bus.mem_write_address_o = '0;
        bus.mem_write_data_o    = '0;
        bus.mem_wr_ena_o        = 1'b0;
        if (w_eng) begin
            bus.mem_read_address_o  = bus.eng_read_address_i;
            bus.mem_write_address_o = bus.eng_write_address_i;
            bus.mem_write_data_o    = bus.eng_write_data_i;
            bus.mem_wr_ena_o        = bus.eng_wr_ena_i;
        end else if (w_pop) begin
            bus.mem_write_address_o = w_head[FW-1:DATA_WIDTH];
            bus.mem_write_data_o    = w_head[DATA_WIDTH-1:0];
            bus.mem_wr_ena_o        = 1'b1;
        end
    end
endmodule

// File: tb/tb_cell_mem_scheduler.sv
// Randomised bench for cell_mem_scheduler against a queue-based model.
// Honours CELL_SCHED_WATCHDOG_EN for the watchdog scenario.
module tb_cell_mem_scheduler;
    import sand_pkg::*;

    localparam int SD    = 2;
    localparam int DEPTH = 4;
    localparam int TO    = 50;
    localparam int AW    = ADDR_WIDTH;
`ifdef CELL_SCHED_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cell_mem_scheduler_if bus ();

    cell_mem_scheduler #(
        .STEP_DIVIDE    (SD),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: 0=idle, 1=start, 2=step.
    int              m_mode = 0;
    int              m_ticks = 0;
    bit              m_owed = 0;
    bit              m_ovr = 0;
    bit              m_tmo = 0;
    int              m_steps_run = 0;
    logic [AW:0]     m_q[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        bit          trig;
        bit          pop;
        bit          eng;
        logic [AW:0] h;
        logic [AW-1:0] e_ra, e_wa;
        logic        e_wd, e_we;
        #2;
        trig = bus.frame_tick_i && ((m_ticks % SD) == SD - 1);
        eng  = !rst && m_mode != 0;
        pop  = !rst && m_mode == 0 && !trig && !m_owed &&
               m_q.size() > 0;
        h    = (m_q.size() > 0) ? m_q[0] : '0;
        e_ra = eng ? bus.eng_read_address_i : '0;
        e_wa = eng ? bus.eng_write_address_i : (pop ? h[AW:1] : '0);
        e_wd = eng ? bus.eng_write_data_i : (pop ? h[0] : 1'b0);
        e_we = eng ? bus.eng_wr_ena_i : pop;
        chk("rd_addr", 32'(bus.mem_read_address_o), 32'(e_ra));
        chk("wr_addr", 32'(bus.mem_write_address_o), 32'(e_wa));
        chk("wr_data", 32'(bus.mem_write_data_o), 32'(e_wd));
        chk("wr_ena", 32'(bus.mem_wr_ena_o), 32'(e_we));
        chk("eng_ready", 32'(bus.eng_ready_o),
            32'(!rst && m_mode == 1));
        chk("busy", 32'(bus.busy_o), 32'(eng));
        chk("spawn_ready", 32'(bus.spawn_ready_o),
            32'(rst || m_q.size() < DEPTH));
        chk("overrun", 32'(bus.overrun_o), 32'(!rst && m_ovr));
        chk("timeout", 32'(bus.timeout_o), 32'(!rst && m_tmo));
        if (rst) begin
            m_mode = 0; m_ticks = 0; m_owed = 0;
            m_ovr = 0; m_tmo = 0; m_q.delete();
        end else begin
            bit can_push;
            can_push = m_q.size() < DEPTH;
            if (pop) void'(m_q.pop_front());
            if (bus.spawn_valid_i && can_push)
                m_q.push_back({bus.spawn_address_i, bus.spawn_data_i});
            if (bus.frame_tick_i) m_ticks++;
            if (trig && m_mode != 0) begin
                m_owed = 1; m_ovr = 1;
            end
            case (m_mode)
                0: if (trig || m_owed) begin
                    m_mode = 1; m_owed = 0; m_steps_run = 0;
                end
                1: m_mode = 2;
                default: begin
                    m_steps_run++;
                    if (bus.eng_done_i) m_mode = 0;
                    else if (WD && m_steps_run == TO) begin
                        m_mode = 0; m_tmo = 1;
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.frame_tick_i        = 0;
        bus.eng_done_i          = 0;
        bus.eng_wr_ena_i        = 0;
        bus.eng_read_address_i  = '0;
        bus.eng_write_address_i = '0;
        bus.eng_write_data_i    = '0;
        bus.spawn_valid_i       = 0;
        bus.spawn_address_i     = '0;
        bus.spawn_data_i        = '0;
    endtask

    task automatic quiesce();
        int n;
        drive_idle();
        n = 0;
        while (!(m_mode == 0 && !m_owed && m_q.size() == 0) && n < 100) begin
            bus.eng_done_i = (m_mode == 2);
            cyc();
            n++;
        end
        bus.eng_done_i = 0;
        if (n >= 100) chk("quiesce_bound", 0, 1);
    endtask

    task automatic start_step();
        int n;
        n = 0;
        while (m_mode != 2 && n < 10) begin
            bus.frame_tick_i = (m_mode == 0);
            cyc();
            n++;
        end
        bus.frame_tick_i = 0;
        if (n >= 10) chk("start_bound", 0, 1);
    endtask

    initial begin
        drive_idle();
        @(posedge clk);
        #1;
        repeat (2) cyc();
        rst = 0;
        repeat (5) cyc();

        // Two ticks needed per step; start pulse the cycle after the second.
        bus.frame_tick_i = 1; cyc();
        bus.frame_tick_i = 0; repeat (9) cyc();
        bus.frame_tick_i = 1; cyc();
        bus.frame_tick_i = 0;
        chk("start_pulse", 32'(bus.eng_ready_o), 1);
        cyc();

        bus.eng_read_address_i  = 19'd641;
        bus.eng_write_address_i = 19'd1280;
        bus.eng_write_data_i    = 1'b1;
        bus.eng_wr_ena_i        = 1;
        repeat (2) cyc();
        bus.eng_write_address_i = 19'd320;
        bus.eng_done_i          = 1;
        cyc();
        drive_idle();
        repeat (2) cyc();

        start_step();
        for (int i = 0; i < 4; i++) begin
            bus.spawn_valid_i   = 1;
            bus.spawn_address_i = AW'(5 + i);
            bus.spawn_data_i    = cell_t'($urandom_range(0, 1));
            cyc();
        end
        bus.spawn_valid_i = 0;
        chk("fifo_full", 32'(bus.spawn_ready_o), 0);
        repeat (3) cyc();
        bus.eng_done_i = 1; cyc();
        bus.eng_done_i = 0;
        repeat (6) cyc();

        start_step();
        bus.spawn_valid_i   = 1;
        bus.spawn_address_i = 19'd99;
        bus.spawn_data_i    = 1'b1;
        bus.frame_tick_i    = 1;
        repeat (2) cyc();
        drive_idle();
        chk("overrun_set", 32'(bus.overrun_o), 1);
        bus.eng_done_i = 1; cyc();
        bus.eng_done_i = 0;
        repeat (6) cyc();

        for (int i = 0; i < 3000; i++) begin
            bus.frame_tick_i        = ($urandom_range(0, 9) == 0);
            bus.eng_done_i          = ($urandom_range(0, 5) == 0);
            bus.eng_wr_ena_i        = $urandom_range(0, 1);
            bus.eng_read_address_i  = AW'($urandom_range(0, 307199));
            bus.eng_write_address_i = AW'($urandom_range(0, 307199));
            bus.eng_write_data_i    = cell_t'($urandom_range(0, 1));
            bus.spawn_valid_i       = ($urandom_range(0, 2) == 0);
            bus.spawn_address_i     = AW'($urandom_range(0, 307199));
            bus.spawn_data_i        = cell_t'($urandom_range(0, 1));
            if (i == 1500) rst = 1;
            if (i == 1502) rst = 0;
            cyc();
        end

        quiesce();
        start_step();
        repeat (40) cyc();
        chk("still_busy_40", 32'(bus.busy_o), 1);
        repeat (170) cyc();
        chk("wdog_busy", 32'(bus.busy_o), WD ? 0 : 1);
        chk("wdog_flag", 32'(bus.timeout_o), WD ? 1 : 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cell_mem_scheduler.md
Name: cell_mem_scheduler

Overview:
- Frame-level sequencer and port arbiter for the single-port cell RAM.
- Triggers one simulation step of the next-state engine every STEP_DIVIDE frame ticks and gives the engine exclusive use of the RAM port while it runs.
- Between steps, drains a small FIFO of brush/spawn writes (user-drawn sand) into the RAM.
- Sits between the input/brush logic, the next-state engine and the cell RAM write/read port.

Parameters:
- ACTIVE_COLUMNS, 640, cells per row.
- ACTIVE_ROWS, 480, rows.
- ADDR_WIDTH, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), cell address width.
- DATA_WIDTH, 1, cell state width.
- STEP_DIVIDE, 1, frame ticks per simulation step (>=1).
- FIFO_DEPTH, 4, spawn FIFO entries (power of 2).
- TIMEOUT_CYCLES, 1228800, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- frame_tick_i  in  1  one-cycle pulse per video frame
- eng_ready_o  out  1  one-cycle start pulse to engine
- eng_done_i  in  1  engine step complete (one-cycle pulse)
- eng_read_address_i  in  ADDR_WIDTH  engine read address
- eng_write_address_i  in  ADDR_WIDTH  engine write address
- eng_write_data_i  in  DATA_WIDTH  engine write data
- eng_wr_ena_i  in  1  engine write enable
- spawn_valid_i  in  1  spawn request valid
- spawn_address_i  in  ADDR_WIDTH  spawn cell address
- spawn_data_i  in  DATA_WIDTH  spawn cell value
- spawn_ready_o  out  1  FIFO can accept
- mem_read_address_o  out  ADDR_WIDTH  RAM read address
- mem_write_address_o  out  ADDR_WIDTH  RAM write address
- mem_write_data_o  out  DATA_WIDTH  RAM write data
- mem_wr_ena_o  out  1  RAM write enable
- busy_o  out  1  engine owns RAM (START or STEP)
- overrun_o  out  1  sticky: step trigger arrived while busy
- timeout_o  out  1  sticky watchdog flag (0 without macro)

Behaviour:
- Reset
  - Synchronous, active-high; takes effect mid-step with no handshake.
  - state=IDLE; FIFO emptied; divider, pending, flags cleared.
  - Output values under reset: all outputs 0 except spawn_ready_o=1.
- Divider
  - Increments on each frame_tick_i.
  - When it reaches STEP_DIVIDE-1 and a tick occurs, it wraps to 0 and raises the trigger.
- States: IDLE, START, STEP.
- IDLE
  - If the trigger fires or pending=1: go to START, clear pending. No FIFO pop that cycle.
  - Otherwise, if the FIFO is non-empty: pop the head and drive mem_wr_ena_o=1 with the head address/data, combinationally, in the same cycle.
- START
  - eng_ready_o=1 for exactly one cycle; RAM mux selects the engine; go to STEP.
- STEP
  - Mux selects the engine.
  - On eng_done_i=1: the engine's write in that cycle still reaches RAM; go to IDLE next cycle.
- Trigger while in START or STEP
  - Set pending=1 and overrun_o=1 (sticky until reset).
  - Additional triggers while pending is already set are absorbed; only one step is owed.
- RAM mux
  - Combinational from the registered state, zero latency, so the engine's synchronous-read timing is preserved.
  - When the engine is not selected: read address=0; write port driven by the FIFO pop or all 0.
- FIFO
  - spawn_ready_o = !full; pushes are accepted in any state when valid && ready.
  - Push and pop in the same cycle are both performed. When full, ready is low even if a pop occurs that cycle.
  - Minimum push-to-RAM latency: 1 cycle.
  - Pops happen only in IDLE; entries are held across steps.
- eng_done_i outside STEP is ignored.

Optional Feature:
- Macro: CELL_SCHED_WATCHDOG_EN.
- With macro
  - A cycle counter runs in STEP.
  - If it reaches TIMEOUT_CYCLES without eng_done_i: set timeout_o (sticky) and return to IDLE, releasing the RAM.
  - The counter clears on entering START.
- Without macro
  - No counter is built; timeout_o tied 0; STEP waits indefinitely.

Decomposition:
- Shared package sand_pkg:
  - ACTIVE_COLUMNS and ACTIVE_ROWS constants.
  - cell_t (logic [DATA_WIDTH-1:0]).
  - sched_state_t enum {IDLE, START, STEP}.
- One sub-module, spawn_fifo:
  - Synchronous FIFO with parameterised width and depth.
  - Ports: push, pop, full, empty, head data.

Test Plan:
- Reset
  - Stimulus: hold reset_i 2 cycles, then run 5 cycles.
  - Required: all mem_* = 0, eng_ready_o=0, spawn_ready_o=1, busy_o=0.
- Basic step, STEP_DIVIDE=2
  - Stimulus: ticks at cycles 10 and 20.
  - Required: no start after tick 10; eng_ready_o pulse at cycle 21; busy_o high until done+1.
- Engine ownership
  - Stimulus: in STEP, engine drives read=641, write=1280 data=1 en=1.
  - Required: mem_* mirror these in the same cycle.
  - Stimulus: eng_done_i with write=320.
  - Required: the write reaches RAM.
- Spawn drain
  - Stimulus: push addresses 5, 6, 7, 8 while in STEP.
  - Required: spawn_ready_o=0 after the 4th push; RAM untouched until done.
  - Then, in the 4 IDLE cycles after STEP: writes to 5, 6, 7, 8 in order, data intact.
- Overrun
  - Stimulus: trigger mid-STEP, then eng_done_i.
  - Required: overrun_o=1; after IDLE, START and eng_ready_o follow 1 cycle later with no spawn pop in between.
- Watchdog (macro on, TIMEOUT_CYCLES=50)
  - Stimulus: never assert eng_done_i.
  - Required: timeout_o=1 and busy_o=0 at cycle 50 of STEP.
  - Without the macro: still busy at cycle 200.
